// File: rtl/core_scheduler.sv
// Per-core block scheduler: sequences fetch/decode/execute/memory-wait/update
// for one thread block and hands a done pulse back to the dispatcher.
//
// state   | meaning
// IDLE    | waiting for a start pulse from the dispatcher
// FETCH   | fetch_req held until fetch_valid returns the instruction
// DECODE  | count the instruction, RET ends the block
// EXECUTE | one-cycle exec strobe, mem_req for LDR/STR
// MEMWAIT | collect per-lane LSU completions for enabled lanes
// UPDATE  | advance pc or take a uniform branch
// DONE    | one-cycle done pulse, lanes disabled
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int ADDR_BITS         = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [7:0]                         block_id,
  input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
  output logic                               done,
  output logic                               busy,
  output logic [7:0]                         cur_block_id,
  output logic [THREADS_PER_BLOCK-1:0]       thread_enable,
  output logic                               fetch_req,
  output logic [ADDR_BITS-1:0]               fetch_addr,
  input  logic                               fetch_valid,
  input  logic [15:0]                        fetch_instr,
  input  logic                               branch_taken,
  output logic                               exec_en,
  output logic                               mem_req,
  input  logic [THREADS_PER_BLOCK-1:0]       lsu_done,
  output logic [15:0]                        instr_count
);

  localparam int T   = THREADS_PER_BLOCK;
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  localparam logic [3:0] OP_BR  = 4'b0001;
  localparam logic [3:0] OP_LDR = 4'b0111;
  localparam logic [3:0] OP_STR = 4'b1000;
  localparam logic [3:0] OP_RET = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEMWAIT = 3'd4,
    UPDATE  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q;
  logic [15:0]          instr_q;
  logic [15:0]          icount_q;
  logic [7:0]           block_q;
  logic [T-1:0]         te_q;
  logic [T-1:0]         mask_q;
  logic [T-1:0]         te_start;
  logic [3:0]           opcode;
  logic                 is_mem;
  logic                 lanes_done;

  assign opcode     = instr_q[15:12];
  assign is_mem     = (opcode == OP_LDR) || (opcode == OP_STR);
  // Disabled lanes are masked out on both sides, so their lsu_done bits never matter.
  assign lanes_done = ((mask_q | lsu_done) & te_q) == te_q;

  always_comb begin
    te_start = '0;
    for (int i = 0; i < T; i++) te_start[i] = (thread_count > TCW'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    exec_en   = 1'b0;
    mem_req   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = (thread_count == '0) ? DONE : FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_valid) state_d = DECODE;
      end
      DECODE:  state_d = (opcode == OP_RET) ? DONE : EXECUTE;
      EXECUTE: begin
        exec_en = 1'b1;
        mem_req = is_mem;
        state_d = is_mem ? MEMWAIT : UPDATE;
      end
      MEMWAIT: if (lanes_done) state_d = UPDATE;
      UPDATE:  state_d = FETCH;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      icount_q <= '0;
      block_q  <= '0;
      te_q     <= '0;
      mask_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          block_q  <= block_id;
          pc_q     <= '0;
          icount_q <= '0;
          mask_q   <= '0;
          te_q     <= te_start;
        end
        FETCH:   if (fetch_valid) instr_q <= fetch_instr;
        DECODE:  if (icount_q != 16'hFFFF) icount_q <= icount_q + 16'd1;
        MEMWAIT: mask_q <= lanes_done ? '0 : (mask_q | (lsu_done & te_q));
        UPDATE: begin
          if (opcode == OP_BR && branch_taken) pc_q <= instr_q[ADDR_BITS-1:0];
          else                                 pc_q <= pc_q + ADDR_BITS'(1);
        end
        DONE:    te_q <= '0;
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign cur_block_id  = block_q;
  assign thread_enable = te_q;
  assign fetch_addr    = pc_q;
  assign instr_count   = icount_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: a program-level model predicts the fetch address
// trace, instruction/exec/memory counts and LSU wait lengths for each block.
module tb_core_scheduler;
  localparam int T  = 4;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    block_id;
  logic [2:0]    thread_count;
  logic          done;
  logic          busy;
  logic [7:0]    cur_block_id;
  logic [T-1:0]  thread_enable;
  logic          fetch_req;
  logic [AB-1:0] fetch_addr;
  logic          fetch_valid;
  logic [15:0]   fetch_instr;
  logic          branch_taken;
  logic          exec_en;
  logic          mem_req;
  logic [T-1:0]  lsu_done;
  logic [15:0]   instr_count;

  core_scheduler #(.THREADS_PER_BLOCK(T), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .block_id(block_id),
    .thread_count(thread_count), .done(done), .busy(busy),
    .cur_block_id(cur_block_id), .thread_enable(thread_enable),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .branch_taken(branch_taken), .exec_en(exec_en),
    .mem_req(mem_req), .lsu_done(lsu_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] prog [256];
  bit          bt_seq [64];
  logic [7:0]  exp_addr [$];
  int          exp_mem;
  logic [3:0]  pat_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the program as the block would run it; returns 1 if it reaches RET.
  function automatic bit build_trace();
    logic [7:0]  pc;
    logic [15:0] ins;
    pc = 8'd0;
    exp_addr.delete();
    exp_mem = 0;
    for (int s = 0; s < 24; s++) begin
      exp_addr.push_back(pc);
      ins = prog[pc];
      if (ins[15:12] == 4'hF) return 1'b1;
      if (ins[15:12] == 4'h7 || ins[15:12] == 4'h8) exp_mem++;
      if (ins[15:12] == 4'h1 && bt_seq[s]) pc = ins[7:0];
      else pc = pc + 8'd1;
    end
    return 1'b0;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    for (int i = 0; i < 64; i++) bt_seq[i] = 1'b0;
  endtask

  task automatic random_prog();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      prog[i] = {4'(2 + $urandom_range(0, 4)), 12'($urandom)};
      else if (r == 5) prog[i] = {4'h7, 12'($urandom)};
      else if (r == 6) prog[i] = {4'h8, 12'($urandom)};
      else if (r <= 8) prog[i] = {4'h1, 12'($urandom)};
      else             prog[i] = {4'hF, 12'($urandom)};
    end
    for (int i = 0; i < 64; i++) bt_seq[i] = 1'($urandom);
    if (!build_trace()) begin
      prog[exp_addr[exp_addr.size()-1]] = 16'hF000;
      void'(build_trace());
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cur_block_id"}, cur_block_id, 0);
    chk({tag, "_thread_enable"}, thread_enable, 0);
    chk({tag, "_fetch_req"}, fetch_req, 0);
    chk({tag, "_fetch_addr"}, fetch_addr, 0);
    chk({tag, "_exec_en"}, exec_en, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_instr_count"}, instr_count, 0);
  endtask

  // fixed_lat < 0 picks a random fetch latency of 0..3 cycles per fetch.
  task automatic run_block(input logic [7:0] bid, input logic [2:0] tc, input bit poke,
                           input bit abort, input int fixed_lat);
    logic [3:0] te_exp, cum;
    logic [3:0] pats [$];
    int fidx = 0, exec_c = 0, mem_c = 0, done_c = 0, post = 0;
    int lat = -1, mw_exp = -1, mw_cnt = 0, k = 0, n;
    bit poked = 1'b0, fin = 1'b0, aborted = 1'b0;
    te_exp = (tc >= 3'd4) ? 4'hF : 4'((5'd1 << tc) - 5'd1);
    if (tc == 3'd0) begin
      exp_addr.delete();
      exp_mem = 0;
    end
    n = exp_addr.size();
    @(negedge clk);
    block_id = bid; thread_count = tc; start = 1'b1; fetch_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (tc == 3'd0) chk("zero_tc_done_next_cycle", done, 1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      start = 1'b0;
      fetch_valid = 1'b0;
      lsu_done = 4'($urandom);
      if (mw_exp >= 0) mw_cnt++;
      if (busy) chk("te_while_busy", thread_enable, te_exp);
      if (fetch_req) begin
        if (mw_exp >= 0) begin
          chk("memwait_exit_cycles", mw_cnt, mw_exp);
          mw_exp = -1;
        end
        if (fidx < n) chk("fetch_addr", fetch_addr, exp_addr[fidx]);
        else          chk("extra_fetch", fidx, n - 1);
        if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        if (lat == 0) begin
          fetch_valid  = 1'b1;
          fetch_instr  = (fidx < n) ? prog[exp_addr[fidx]] : 16'hF000;
          branch_taken = bt_seq[fidx % 64];
          fidx++;
          lat = -1;
        end else lat--;
      end else begin
        fetch_valid = 1'($urandom);
        fetch_instr = 16'($urandom);
      end
      if (exec_en) exec_c++;
      if (mem_req) begin
        mem_c++;
        if (pat_q.size() > 0) begin
          pats = pat_q;
          pat_q.delete();
        end else begin
          pats.delete();
          for (int j = 0; j < 5; j++) pats.push_back(4'($urandom));
          pats.push_back(4'hF);
        end
        cum = 4'h0;
        k = pats.size();
        for (int j = 0; j < pats.size(); j++) begin
          cum = cum | pats[j];
          if ((cum & te_exp) == te_exp) begin
            k = j + 1;
            break;
          end
        end
        mw_exp = k + 2;
        mw_cnt = 0;
      end
      if (mw_exp >= 0 && mw_cnt >= 1 && mw_cnt <= pats.size()) lsu_done = pats[mw_cnt-1];
      if (done) begin
        done_c++;
        chk("instr_count_at_done", instr_count, n);
        chk("cur_block_id_at_done", cur_block_id, bid);
      end
      if (done_c > 0) begin
        post++;
        if (post == 4) fin = 1'b1;
      end
      if (poke && !poked && fidx >= 1) begin
        start = 1'b1;
        block_id = ~bid;
        poked = 1'b1;
      end
      if (abort && mw_exp >= 0 && mw_cnt == 1) begin
        #2 reset = 1'b1;
        #1 check_all_zero("reset_in_memwait");
        @(posedge clk);
        #1 chk("reset_hold_busy", busy, 0);
        chk("reset_hold_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
        fin = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (aborted) begin
      for (int j = 0; j < 4; j++) begin
        if (done) done_c++;
        @(negedge clk);
      end
      chk("abort_no_done", done_c, 0);
      chk("abort_idle_busy", busy, 0);
    end else begin
      chk("done_pulse_count", done_c, 1);
      chk("busy_after_done", busy, 0);
      chk("te_cleared_after_done", thread_enable, 0);
      chk("exec_pulses", exec_c, (n > 0) ? n - 1 : 0);
      chk("mem_req_pulses", mem_c, exp_mem);
      chk("fetch_count", fidx, n);
      chk("instr_count_stable", instr_count, n);
      chk("cur_block_id_stable", cur_block_id, bid);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; block_id = 8'h0; thread_count = 3'd0;
    fetch_valid = 1'b0; fetch_instr = 16'h0; branch_taken = 1'b0; lsu_done = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    // ADD then RET, four lanes, fetch answered one cycle after the request
    clear_prog();
    prog[0] = 16'h0000;
    void'(build_trace());
    run_block(8'd3, 3'd4, 1'b0, 1'b0, 1);

    // LDR on two lanes: 1100 is all disabled lanes, exit only once 0010 arrives
    clear_prog();
    prog[0] = 16'h7000;
    void'(build_trace());
    pat_q = '{4'b1100, 4'b0001, 4'b0010};
    run_block(8'h41, 3'd2, 1'b0, 1'b0, -1);

    // empty block
    clear_prog();
    void'(build_trace());
    run_block(8'h42, 3'd0, 1'b0, 1'b0, -1);

    // taken branch to 0x10, branch to 0xFF, wrap to 0, untaken branch, RET
    clear_prog();
    prog[8'h00] = 16'h1010; bt_seq[0] = 1'b1;
    prog[8'h10] = 16'h10FF; bt_seq[1] = 1'b1;
    prog[8'hFF] = 16'h2000;
    bt_seq[3] = 1'b0;
    void'(build_trace());
    run_block(8'h43, 3'd3, 1'b0, 1'b0, -1);

    // reset while waiting on a store, then a normal block from pc 0
    clear_prog();
    prog[0] = 16'h8000;
    void'(build_trace());
    run_block(8'h44, 3'd4, 1'b0, 1'b1, -1);
    clear_prog();
    prog[0] = 16'h0000; prog[1] = 16'h7000;
    void'(build_trace());
    run_block(8'h45, 3'd3, 1'b0, 1'b0, -1);

    // oversized thread_count and a start pulse while busy
    clear_prog();
    prog[0] = 16'h0000;
    void'(build_trace());
    run_block(8'h46, 3'd7, 1'b1, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      random_prog();
      run_block(8'($urandom), 3'($urandom), 1'($urandom), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
